// File: rtl/spsram_ctrl.sv
// ---------------------------------------------------------------------------
// spsram_ctrl
//
// Request/response front-end for a single-port synchronous SRAM with a
// registered read port (1-cycle read latency, cen/wen/oen controls).
// A valid/ready request stream of reads and writes is turned into legal
// SRAM command cycles. Read data is captured from the SRAM and returned on
// a valid/ready response channel that supports back-pressure. At most one
// read is outstanding. Writes complete in the cycle they are accepted.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rstn       asynchronous active-low reset
//   i_req_valid  request present
//   o_req_ready  controller can accept a request this cycle
//   i_req_wr     1 = write, 0 = read
//   i_req_addr   request address
//   i_req_wdata  write data
//   o_rsp_valid  read response valid
//   i_rsp_ready  consumer accepts the response
//   o_rsp_rdata  read response data
//   o_mem_cen    SRAM chip enable
//   o_mem_wen    SRAM write enable
//   o_mem_oen    SRAM output enable
//   o_mem_addr   SRAM address
//   o_mem_data   SRAM write data
//   i_mem_data   SRAM registered read data (valid 1 cycle after command)
//   o_busy       1 whenever the controller is not idle
// ---------------------------------------------------------------------------
module spsram_ctrl #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_wr,
    input  logic [BW_ADDR-1:0] i_req_addr,
    input  logic [BW_DATA-1:0] i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_rdata,
    output logic               o_mem_cen,
    output logic               o_mem_wen,
    output logic               o_mem_oen,
    output logic [BW_ADDR-1:0] o_mem_addr,
    output logic [BW_DATA-1:0] o_mem_data,
    input  logic [BW_DATA-1:0] i_mem_data,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 rspValid_q;
    logic [BW_DATA-1:0]   rdata_q;
    logic                 accept;

    // Ready is combinational so a response hand-off in RSP can overlap with
    // accepting the next request, giving one read every two cycles.
    always_comb begin
        o_req_ready = (state_q == IDLE) || ((state_q == RSP) && i_rsp_ready);
        accept      = i_req_valid && o_req_ready;
    end

    // The SRAM is driven straight from the request; command strobes only
    // fire on an accepted request. Output enable stays high through RD so
    // the SRAM keeps presenting the read data while it is captured.
    always_comb begin
        o_mem_addr = i_req_addr;
        o_mem_data = i_req_wdata;
        o_mem_cen  = accept;
        o_mem_wen  = accept && i_req_wr;
        o_mem_oen  = (accept && !i_req_wr) || (state_q == RD);
        o_busy     = (state_q != IDLE);
        o_rsp_valid = rspValid_q;
        o_rsp_rdata = rdata_q;
    end

    // Control FSM. Read data is captured at the end of RD, so a write that
    // is accepted in the same cycle the response is handed off cannot
    // disturb the response already held in rdata_q.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= INIT;
            rspValid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q <= IDLE;
                end
                IDLE: begin
                    if (accept && !i_req_wr) begin
                        state_q <= RD;
                    end
                end
                RD: begin
                    rdata_q    <= i_mem_data;
                    rspValid_q <= 1'b1;
                    state_q    <= RSP;
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        rspValid_q <= 1'b0;
                        if (accept && !i_req_wr) begin
                            state_q <= RD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spsram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spsram_ctrl
//
// Directed testbench for spsram_ctrl. A behavioural single-port SRAM with a
// registered read port sits behind the controller. Inputs are driven 1 ns
// after the rising edge and outputs are sampled 1 ns later, away from the
// clock edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spsram_ctrl;

    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;

    logic               i_clk;
    logic               i_rstn;
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_wr;
    logic [BW_ADDR-1:0] i_req_addr;
    logic [BW_DATA-1:0] i_req_wdata;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [BW_DATA-1:0] o_rsp_rdata;
    logic               o_mem_cen;
    logic               o_mem_wen;
    logic               o_mem_oen;
    logic [BW_ADDR-1:0] o_mem_addr;
    logic [BW_DATA-1:0] o_mem_data;
    logic [BW_DATA-1:0] i_mem_data;
    logic               o_busy;

    int testCount;
    int failCount;

    logic [BW_DATA-1:0] sramMem [2**BW_ADDR];

    spsram_ctrl #(
        .BW_DATA(BW_DATA),
        .BW_ADDR(BW_ADDR)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wr    (i_req_wr),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_mem_cen   (o_mem_cen),
        .o_mem_wen   (o_mem_wen),
        .o_mem_oen   (o_mem_oen),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .i_mem_data  (i_mem_data),
        .o_busy      (o_busy)
    );

    // 10 ns clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Behavioural SRAM: write on cen&wen, registered read on cen&!wen
    always @(posedge i_clk) begin
        if (o_mem_cen) begin
            if (o_mem_wen) begin
                sramMem[o_mem_addr] <= o_mem_data;
            end else begin
                i_mem_data <= sramMem[o_mem_addr];
            end
        end
    end

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    // Drive one request onto the request channel
    task automatic applyStimulus(input logic valid, input logic wr,
                                 input logic [BW_ADDR-1:0] addr,
                                 input logic [BW_DATA-1:0] wdata,
                                 input logic rspReady);
        i_req_valid = valid;
        i_req_wr    = wr;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_rsp_ready = rspReady;
    endtask

    // One comparison point
    task automatic checkOutput(input string tag, input logic [BW_DATA-1:0] observed,
                               input logic [BW_DATA-1:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        i_rstn      = 1'b0;
        i_mem_data  = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);

        // Reset state
        tick();
        tick();
        checkOutput("rst_ready", {31'd0, o_req_ready}, 32'd0);
        checkOutput("rst_rspv",  {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("rst_busy",  {31'd0, o_busy}, 32'd1);
        checkOutput("rst_cen",   {31'd0, o_mem_cen}, 32'd0);
        checkOutput("rst_rdata", o_rsp_rdata, 32'd0);

        // Release reset: INIT for exactly one cycle, then IDLE
        i_rstn = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd0, '0, 1'b1);
        settle();
        checkOutput("init_ready", {31'd0, o_req_ready}, 32'd0);
        checkOutput("init_busy",  {31'd0, o_busy}, 32'd1);
        checkOutput("init_cen",   {31'd0, o_mem_cen}, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1);
        tick();
        checkOutput("idle_ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("idle_busy",  {31'd0, o_busy}, 32'd0);
        checkOutput("idle_rspv",  {31'd0, o_rsp_valid}, 32'd0);

        // Write 0xDEADBEEF @3, then read it back
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
        settle();
        checkOutput("wr_cen",  {31'd0, o_mem_cen}, 32'd1);
        checkOutput("wr_wen",  {31'd0, o_mem_wen}, 32'd1);
        checkOutput("wr_oen",  {31'd0, o_mem_oen}, 32'd0);
        checkOutput("wr_addr", {27'd0, o_mem_addr}, 32'd3);
        checkOutput("wr_data", o_mem_data, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd3, 32'h0, 1'b1);
        settle();
        checkOutput("rd_cen", {31'd0, o_mem_cen}, 32'd1);
        checkOutput("rd_wen", {31'd0, o_mem_wen}, 32'd0);
        checkOutput("rd_oen", {31'd0, o_mem_oen}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        settle();
        checkOutput("rdst_rspv",  {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("rdst_ready", {31'd0, o_req_ready}, 32'd0);
        checkOutput("rdst_oen",   {31'd0, o_mem_oen}, 32'd1);
        checkOutput("rdst_cen",   {31'd0, o_mem_cen}, 32'd0);
        checkOutput("rdst_busy",  {31'd0, o_busy}, 32'd1);
        tick();
        checkOutput("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        checkOutput("rsp_data",  o_rsp_rdata, 32'hDEADBEEF);
        tick();
        checkOutput("rsp_drop",  {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("rsp_hold",  o_rsp_rdata, 32'hDEADBEEF);

        // Fill all 32 words back-to-back with address + 0x100
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
            settle();
            checkOutput("fill_ready", {31'd0, o_req_ready}, 32'd1);
            tick();
        end

        // Read all 32 words, one response every two cycles
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i), 32'h0, 1'b1);
            settle();
            if (i > 0) begin
                checkOutput("seq_rspv", {31'd0, o_rsp_valid}, 32'd1);
                checkOutput("seq_data", o_rsp_rdata, 32'h100 + 32'(i - 1));
            end
            checkOutput("seq_cen", {31'd0, o_mem_cen}, 32'd1);
            tick();
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
            settle();
            checkOutput("seq_rd_rspv", {31'd0, o_rsp_valid}, 32'd0);
            tick();
        end
        checkOutput("seq_last_rspv", {31'd0, o_rsp_valid}, 32'd1);
        checkOutput("seq_last_data", o_rsp_rdata, 32'h11F);
        tick();
        checkOutput("seq_end_rspv", {31'd0, o_rsp_valid}, 32'd0);

        // Read @5 with back-pressure; request held high is not accepted
        applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_rspv",  {31'd0, o_rsp_valid}, 32'd1);
            checkOutput("bp_data",  o_rsp_rdata, 32'h105);
            checkOutput("bp_ready", {31'd0, o_req_ready}, 32'd0);
            checkOutput("bp_cen",   {31'd0, o_mem_cen}, 32'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, 1'b1);
        settle();
        checkOutput("bp_rel_ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("bp_rel_cen",   {31'd0, o_mem_cen}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        settle();
        checkOutput("b2b_rd_rspv", {31'd0, o_rsp_valid}, 32'd0);
        tick();

        // In RSP: hand off response while writing 0x1 @5
        applyStimulus(1'b1, 1'b1, 5'd5, 32'h1, 1'b1);
        settle();
        checkOutput("ovl_rspv", {31'd0, o_rsp_valid}, 32'd1);
        checkOutput("ovl_data", o_rsp_rdata, 32'h105);
        checkOutput("ovl_wen",  {31'd0, o_mem_wen}, 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, 1'b1);
        settle();
        checkOutput("ovl_idle_rspv",  {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("ovl_idle_ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("ovl_idle_data",  o_rsp_rdata, 32'h105);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        tick();
        checkOutput("raw_rspv", {31'd0, o_rsp_valid}, 32'd1);
        checkOutput("raw_data", o_rsp_rdata, 32'h1);
        tick();

        // Reset asserted while in RD
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        i_rstn = 1'b0;
        settle();
        checkOutput("mrst_rspv",  {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("mrst_ready", {31'd0, o_req_ready}, 32'd0);
        checkOutput("mrst_busy",  {31'd0, o_busy}, 32'd1);
        checkOutput("mrst_oen",   {31'd0, o_mem_oen}, 32'd0);
        checkOutput("mrst_rdata", o_rsp_rdata, 32'd0);
        tick();
        checkOutput("mrst_hold_rspv", {31'd0, o_rsp_valid}, 32'd0);
        i_rstn = 1'b1;
        tick();
        checkOutput("mrst_idle_ready", {31'd0, o_req_ready}, 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        settle();
        checkOutput("post_rd_rspv", {31'd0, o_rsp_valid}, 32'd0);
        tick();
        checkOutput("post_rspv", {31'd0, o_rsp_valid}, 32'd1);
        checkOutput("post_data", o_rsp_rdata, 32'h107);
        tick();
        checkOutput("post_idle_rspv", {31'd0, o_rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
